// File: rtl/comb_func_pkg.sv
// Shared constants for comb_func_unit: default truth table and implementation indices.
// Used by comb_func_unit and comb_func_vote.
package comb_func_pkg;

    localparam logic [15:0] TT_MASK_DEFAULT = 16'hF444;

    localparam int IMPL_STR = 0;
    localparam int IMPL_DF  = 1;
    localparam int IMPL_BEH = 2;
    localparam int IMPL_TT  = 3;

    // A 2-2 split in the vote is settled by the behavioural implementation.
    localparam int VOTE_TIE_IDX = IMPL_BEH;

endpackage

// File: rtl/comb_func_vote.sv
// Majority-of-four voter over the implementation results, plus a disagreement flag.
// Purely combinational.
module comb_func_vote
    import comb_func_pkg::*;
(
    input  logic [3:0] results,
    output logic       y,
    output logic       mismatch
);

    logic [2:0] ones;

    always_comb begin
        ones = {2'b00, results[0]} + {2'b00, results[1]}
             + {2'b00, results[2]} + {2'b00, results[3]};
    end

    always_comb begin
        y = results[VOTE_TIE_IDX];
        if (ones >= 3'd3) begin
            y = 1'b1;
        end else if (ones <= 3'd1) begin
            y = 1'b0;
        end
    end

    assign mismatch = (|results) & ~(&results);

endmodule

// File: rtl/comb_func_unit.sv
// Evaluates Y = (A & B) | (C & ~D) four independent ways, votes and registers the result.
// Define COMB_FAULT_INJ_EN to add fault_en/fault_sel for inverting one implementation.
module comb_func_unit
    import comb_func_pkg::*;
#(
    parameter logic [15:0] TT_MASK = TT_MASK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] abcd,
`ifdef COMB_FAULT_INJ_EN
    input  logic       fault_en,
    input  logic [1:0] fault_sel,
`endif
    output logic       out_valid,
    output logic [3:0] y_vec,
    output logic       y,
    output logic       mismatch
);

    logic a, b, c, d;
    logic d_n, ab, cd_n;
    logic y_str, y_df, y_beh, y_tt;
    logic [3:0] results;
    logic [3:0] results_sel;
    logic       vote_y, vote_mismatch;

    assign {a, b, c, d} = abcd;

    // Gate-level structural implementation.
    not g_not_d (d_n, d);
    and g_and_ab (ab, a, b);
    and g_and_cd (cd_n, c, d_n);
    or  g_or_y (y_str, ab, cd_n);

    assign y_df = (a & b) | (c & ~d);

    always_comb begin
        y_beh = 1'b0;
        if (a && b) begin
            y_beh = 1'b1;
        end else if (c && !d) begin
            y_beh = 1'b1;
        end
    end

    assign y_tt = TT_MASK[abcd];

    always_comb begin
        results           = 4'b0000;
        results[IMPL_STR] = y_str;
        results[IMPL_DF]  = y_df;
        results[IMPL_BEH] = y_beh;
        results[IMPL_TT]  = y_tt;
    end

`ifdef COMB_FAULT_INJ_EN
    // The inverted result propagates to y_vec, the vote and the mismatch flag alike.
    assign results_sel = fault_en ? (results ^ (4'b0001 << fault_sel)) : results;
`else
    assign results_sel = results;
`endif

    comb_func_vote u_vote (
        .results  (results_sel),
        .y        (vote_y),
        .mismatch (vote_mismatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y_vec     <= 4'b0000;
            y         <= 1'b0;
            mismatch  <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            y_vec     <= results_sel;
            y         <= vote_y;
            mismatch  <= vote_mismatch;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_comb_func_unit.sv
// Self-checking bench for comb_func_unit: directed plan plus randomized traffic
// compared against a behavioural model of the Boolean function and 4-way vote.
module tb_comb_func_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] abcd;
    logic       fault_en;
    logic [1:0] fault_sel;
    logic       out_valid;
    logic [3:0] y_vec;
    logic       y;
    logic       mismatch;

    int checkCount;
    int failCount;

    logic       expValid;
    logic [3:0] expVec;
    logic       expY;
    logic       expMis;

    logic [15:0] ttMask;

    comb_func_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .abcd      (abcd),
`ifdef COMB_FAULT_INJ_EN
        .fault_en  (fault_en),
        .fault_sel (fault_sel),
`endif
        .out_valid (out_valid),
        .y_vec     (y_vec),
        .y         (y),
        .mismatch  (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference: evaluate Y arithmetically, apply the optional inversion, vote by counting.
    task automatic modelStep(input logic r, input logic v, input logic [3:0] code,
                             input logic fe, input logic [1:0] fs);
        int a, b, c, d, fy, ones;
        logic [3:0] vec;
        if (r) begin
            expValid = 0; expVec = 0; expY = 0; expMis = 0;
        end else if (v) begin
            a = code[3]; b = code[2]; c = code[1]; d = code[0];
            fy = ((a * b) + (c * (1 - d))) > 0 ? 1 : 0;
            vec = (fy == 1) ? 4'hF : 4'h0;
            if (fe) vec[fs] = ~vec[fs];
            ones = 0;
            for (int i = 0; i < 4; i++) ones += vec[i];
            expVec = vec;
            if (ones >= 3) expY = 1;
            else if (ones <= 1) expY = 0;
            else expY = vec[2];
            expMis = (ones != 0 && ones != 4);
            expValid = 1;
        end else begin
            expValid = 0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] code,
                                 input logic fe, input logic [1:0] fs);
        logic feEff;
`ifdef COMB_FAULT_INJ_EN
        feEff = fe;
`else
        feEff = 1'b0;
`endif
        rst = r; in_valid = v; abcd = code; fault_en = feEff; fault_sel = fs;
        @(posedge clk);
        modelStep(r, v, code, feEff, fs);
        #1;
        checkOutput("out_valid", {3'b0, out_valid}, {3'b0, expValid});
        checkOutput("y_vec", y_vec, expVec);
        checkOutput("y", {3'b0, y}, {3'b0, expY});
        checkOutput("mismatch", {3'b0, mismatch}, {3'b0, expMis});
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        ttMask     = 16'hF444;
        expValid = 0; expVec = 0; expY = 0; expMis = 0;
        rst = 1; in_valid = 0; abcd = 0; fault_en = 0; fault_sel = 0;

        // Reset with a valid input present: reset must win.
        applyStimulus(1, 1, 4'hF, 0, 0);
        applyStimulus(1, 1, 4'hF, 0, 0);
        checkOutput("reset_vec", y_vec, 4'h0);
        checkOutput("reset_valid", {3'b0, out_valid}, 4'h0);

        // Exhaustive sweep of all 16 codes.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 4'(i), 0, 0);
            checkOutput("sweep_tt", {3'b0, y}, {3'b0, ttMask[i]});
        end

        // Hold: one valid sample, then idle.
        applyStimulus(0, 1, 4'hC, 0, 0);
        applyStimulus(0, 0, 4'h0, 0, 0);
        checkOutput("hold_y", {3'b0, y}, 4'h1);
        checkOutput("hold_valid", {3'b0, out_valid}, 4'h0);
        applyStimulus(0, 0, 4'h0, 0, 0);

        // Mid-stream reset.
        applyStimulus(0, 1, 4'h2, 0, 0);
        applyStimulus(0, 1, 4'h2, 0, 0);
        applyStimulus(1, 1, 4'h2, 0, 0);
        checkOutput("midrst_y", {3'b0, y}, 4'h0);
        applyStimulus(0, 1, 4'h2, 0, 0);
        checkOutput("postrst_valid", {3'b0, out_valid}, 4'h1);

`ifdef COMB_FAULT_INJ_EN
        applyStimulus(0, 1, 4'h6, 1, 2'd1);
        checkOutput("fault1_vec", y_vec, 4'b1101);
        applyStimulus(0, 1, 4'h0, 1, 2'd3);
        checkOutput("fault3_vec", y_vec, 4'b1000);
`endif

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                          4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                          2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
